// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller-to-datapath bundle; master = controller, slave = datapath
interface mc_ctrl_if #(parameter int CNT_W = 32);
  logic [31:0]      ctrl_Instr;
  logic             alu_Zero;
  logic             alu_Isbgez;
  logic             ctrl_PCEn;
  logic             ctrl_IorD;
  logic             ctrl_MemWrite;
  logic             ctrl_IRWrite;
  logic             ctrl_RegWrite;
  logic [1:0]       ctrl_RegDst;
  logic             ctrl_MemtoReg;
  logic             ctrl_ALUSrcA;
  logic [1:0]       ctrl_ALUSrcB;
  logic             ctrl_ExtOp;
  logic [2:0]       ctrl_ALUOp;
  logic [1:0]       ctrl_PCSource;
  logic [3:0]       ctrl_State;
  logic [CNT_W-1:0] ctrl_Retired;
  modport master (
    input  ctrl_Instr, alu_Zero, alu_Isbgez,
    output ctrl_PCEn, ctrl_IorD, ctrl_MemWrite, ctrl_IRWrite, ctrl_RegWrite, ctrl_RegDst,
           ctrl_MemtoReg, ctrl_ALUSrcA, ctrl_ALUSrcB, ctrl_ExtOp, ctrl_ALUOp, ctrl_PCSource,
           ctrl_State, ctrl_Retired
  );
  modport slave (
    output ctrl_Instr, alu_Zero, alu_Isbgez,
    input  ctrl_PCEn, ctrl_IorD, ctrl_MemWrite, ctrl_IRWrite, ctrl_RegWrite, ctrl_RegDst,
           ctrl_MemtoReg, ctrl_ALUSrcA, ctrl_ALUSrcB, ctrl_ExtOp, ctrl_ALUOp, ctrl_PCSource,
           ctrl_State, ctrl_Retired
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller FSM with retired-instruction counter.
// Define MC_CTRL_BGEZ_EN to decode bgez (op 000001, rt 00001) as a branch.
module mc_ctrl #(
  parameter int OPC_W = 6,
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  mc_ctrl_if.master  m
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP
  } state_t;
  state_t st, nxt;
  logic [CNT_W-1:0] cnt;
  logic [OPC_W-1:0] opc, funct;
  logic is_r, is_lw, is_sw, is_ori, is_lui, is_beq, is_j, is_bgez, bgez_ok, retire;
  logic [2:0] alu_r;
  logic pcen, iord, memw, irw, regw, m2r, srca, extop;
  logic [1:0] rdst, srcb, psrc;
  logic [2:0] aluop;
  logic unused_ok;
  assign opc    = m.ctrl_Instr[31:26];
  assign funct  = m.ctrl_Instr[5:0];
  assign is_r   = opc == '0 && funct inside {6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b000111};
  assign is_lw  = opc == 6'b100011;
  assign is_sw  = opc == 6'b101011;
  assign is_ori = opc == 6'b001101;
  assign is_lui = opc == 6'b001111;
  assign is_beq = opc == 6'b000100;
  assign is_j   = opc == 6'b000010;
`ifdef MC_CTRL_BGEZ_EN
  assign is_bgez  = opc == 6'b000001 && m.ctrl_Instr[20:16] == 5'b00001;
  assign bgez_ok  = m.alu_Isbgez;
  assign unused_ok = ^{m.ctrl_Instr[25:21], m.ctrl_Instr[15:6]};
`else
  assign is_bgez  = 1'b0;
  assign bgez_ok  = 1'b0;
  assign unused_ok = ^{m.ctrl_Instr[25:6], m.alu_Isbgez};
`endif
  assign alu_r = funct == 6'b100011 ? 3'd3 :
                 funct == 6'b100100 ? 3'd0 :
                 funct == 6'b100101 ? 3'd1 :
                 funct == 6'b000111 ? 3'd5 : 3'd2;
  assign retire = st inside {MEMWB, MEMWR, RWB, IWB, BRANCH, JUMP};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st  <= nxt;
      cnt <= cnt + CNT_W'(retire);
    end
  always_comb begin
    nxt   = FETCH;
    pcen  = 1'b0;
    iord  = 1'b0;
    memw  = 1'b0;
    irw   = 1'b0;
    regw  = 1'b0;
    rdst  = 2'd0;
    m2r   = 1'b0;
    srca  = 1'b0;
    srcb  = 2'd0;
    extop = 1'b0;
    aluop = 3'd0;
    psrc  = 2'd0;
    case (st)
      FETCH: begin
        irw   = 1'b1;
        srcb  = 2'd1;
        aluop = 3'd2;
        pcen  = 1'b1;
        nxt   = DECODE;
      end
      DECODE: begin
        srcb  = 2'd3;
        extop = 1'b1;
        aluop = 3'd2;
        nxt   = is_r ? EXEC_R : (is_lw | is_sw) ? MEMADR : (is_ori | is_lui) ? EXEC_I :
                (is_beq | is_bgez) ? BRANCH : is_j ? JUMP : FETCH;
      end
      MEMADR: begin
        srca  = 1'b1;
        srcb  = 2'd2;
        extop = 1'b1;
        aluop = 3'd2;
        nxt   = is_lw ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        nxt  = MEMWB;
      end
      MEMWB: begin
        regw = 1'b1;
        m2r  = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        memw = 1'b1;
      end
      EXEC_R: begin
        srca  = 1'b1;
        aluop = alu_r;
        nxt   = RWB;
      end
      RWB: begin
        regw = 1'b1;
        rdst = 2'd1;
      end
      EXEC_I: begin
        srcb  = 2'd2;
        aluop = is_lui ? 3'd4 : 3'd1;
        nxt   = IWB;
      end
      IWB: regw = 1'b1;
      BRANCH: begin
        srca  = 1'b1;
        aluop = 3'd3;
        psrc  = 2'd1;
        pcen  = is_beq ? m.alu_Zero : bgez_ok;
      end
      JUMP: begin
        psrc = 2'd2;
        pcen = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
  // write enables are gated by reset so FETCH's PC/IR writes stay off while held
  assign m.ctrl_PCEn     = pcen & reset_n;
  assign m.ctrl_MemWrite = memw & reset_n;
  assign m.ctrl_IRWrite  = irw & reset_n;
  assign m.ctrl_RegWrite = regw & reset_n;
  assign m.ctrl_IorD     = iord;
  assign m.ctrl_RegDst   = rdst;
  assign m.ctrl_MemtoReg = m2r;
  assign m.ctrl_ALUSrcA  = srca;
  assign m.ctrl_ALUSrcB  = srcb;
  assign m.ctrl_ExtOp    = extop;
  assign m.ctrl_ALUOp    = aluop;
  assign m.ctrl_PCSource = psrc;
  assign m.ctrl_State    = st;
  assign m.ctrl_Retired  = cnt;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench; per-cycle expected state/outputs queued per instruction, checked on negedge
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  mc_ctrl_if #(.CNT_W(32)) m_if ();
  mc_ctrl #(.OPC_W(6), .CNT_W(32)) dut (.clk(clk), .reset_n(reset_n), .m(m_if));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  st;
    logic [16:0] out;
    logic [31:0] ret;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0;
  int errs = 0;
  logic [31:0] ret_m = 0;
  logic [16:0] obs;
  assign obs = {m_if.ctrl_PCEn, m_if.ctrl_IorD, m_if.ctrl_MemWrite, m_if.ctrl_IRWrite,
                m_if.ctrl_RegWrite, m_if.ctrl_RegDst, m_if.ctrl_MemtoReg, m_if.ctrl_ALUSrcA,
                m_if.ctrl_ALUSrcB, m_if.ctrl_ExtOp, m_if.ctrl_ALUOp, m_if.ctrl_PCSource};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [16:0] model(input int s, input logic [31:0] ins, input logic z, input logic b);
    logic pcen = 0, iord = 0, memw = 0, irw = 0, regw = 0, m2r = 0, srca = 0, ext = 0;
    logic [1:0] rdst = 0, srcb = 0, psrc = 0;
    logic [2:0] aop = 0;
    case (s)
      0: begin irw = 1; srcb = 1; aop = 2; pcen = 1; end
      1: begin srcb = 3; ext = 1; aop = 2; end
      2: begin srca = 1; srcb = 2; ext = 1; aop = 2; end
      3: iord = 1;
      4: begin regw = 1; m2r = 1; end
      5: begin iord = 1; memw = 1; end
      6: begin
        srca = 1;
        case (ins[5:0])
          6'h21: aop = 2;
          6'h23: aop = 3;
          6'h24: aop = 0;
          6'h25: aop = 1;
          default: aop = 5;
        endcase
      end
      7: begin regw = 1; rdst = 1; end
      8: begin srcb = 2; aop = (ins[31:26] == 6'h0f) ? 3'd4 : 3'd1; end
      9: regw = 1;
      10: begin srca = 1; aop = 3; psrc = 1; pcen = (ins[31:26] == 6'h04) ? z : b; end
      11: begin psrc = 2; pcen = 1; end
      default: ;
    endcase
    return {pcen, iord, memw, irw, regw, rdst, m2r, srca, srcb, ext, aop, psrc};
  endfunction
  function automatic logic [31:0] rt_i(input logic [5:0] fn);
    return {6'd0, 5'd9, 5'd10, 5'd8, 5'd0, fn};
  endfunction
  function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd4, rt, 16'h8123};
  endfunction
  task automatic push_seq(input logic [31:0] ins, input logic z, input logic b, output int n);
    int seq[$];
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    if (op == 0 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25 || fn == 6'h07))
      seq = '{0, 1, 6, 7};
    else if (op == 6'h23) seq = '{0, 1, 2, 3, 4};
    else if (op == 6'h2b) seq = '{0, 1, 2, 5};
    else if (op == 6'h0d || op == 6'h0f) seq = '{0, 1, 8, 9};
    else if (op == 6'h04) seq = '{0, 1, 10};
    else if (op == 6'h02) seq = '{0, 1, 11};
`ifdef MC_CTRL_BGEZ_EN
    else if (op == 6'h01 && ins[20:16] == 5'd1) seq = '{0, 1, 10};
`endif
    else seq = '{0, 1};
    m_if.ctrl_Instr = ins;
    m_if.alu_Zero = z;
    m_if.alu_Isbgez = b;
    foreach (seq[i]) q.push_back('{4'(seq[i]), model(seq[i], ins, z, b), ret_m});
    if (seq.size() > 2) ret_m++;
    n = seq.size();
  endtask
  task automatic run(input logic [31:0] ins, input logic z, input logic b);
    int n;
    push_seq(ins, z, b, n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", 32'(m_if.ctrl_State), 32'(e.st));
      chk("outs", 32'(obs), 32'(e.out));
      chk("retired", m_if.ctrl_Retired, e.ret);
    end
  initial begin
    int n;
    m_if.ctrl_Instr = 32'h0;
    m_if.alu_Zero = 1'b0;
    m_if.alu_Isbgez = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_state", 32'(m_if.ctrl_State), 32'd0);
      chk("rst_outs", 32'(obs), 32'(model(0, 32'h0, 1'b0, 1'b0) & ~17'h17000));
      chk("rst_retired", m_if.ctrl_Retired, 32'd0);
    end
    reset_n = 1'b1;
    run(rt_i(6'h21), 1'b0, 1'b0);
    run(it_i(6'h23, 5'd3), 1'b0, 1'b0);
    run(it_i(6'h2b, 5'd3), 1'b0, 1'b0);
    run(it_i(6'h04, 5'd5), 1'b1, 1'b0);
    run(it_i(6'h04, 5'd5), 1'b0, 1'b1);
    run(it_i(6'h01, 5'd1), 1'b0, 1'b1);
    run(rt_i(6'h23), 1'b0, 1'b0);
    run(rt_i(6'h24), 1'b1, 1'b0);
    run(rt_i(6'h25), 1'b0, 1'b0);
    run(rt_i(6'h07), 1'b0, 1'b0);
    run(it_i(6'h0d, 5'd2), 1'b0, 1'b0);
    run(it_i(6'h0f, 5'd2), 1'b0, 1'b0);
    run({6'h02, 26'h0123456}, 1'b0, 1'b0);
    push_seq(it_i(6'h2b, 5'd3), 1'b0, 1'b0, n);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    chk("memwr_pre", 32'(m_if.ctrl_MemWrite), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_memw", 32'(m_if.ctrl_MemWrite), 32'd0);
    chk("abort_state", 32'(m_if.ctrl_State), 32'd0);
    chk("abort_retired", m_if.ctrl_Retired, 32'd0);
    ret_m = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(rt_i(6'h3f), 1'b0, 1'b0);
    run(it_i(6'h3a, 5'd0), 1'b0, 1'b0);
    run(rt_i(6'h21), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
